// File: rtl/scp_io_pkg.sv
// Shared definitions for the SCP buffered I/O channel unit.
//   - status word layout (bit positions and width)
//   - clog2 helper used to size pointers and the channel select
package scp_io_pkg;

   localparam int ST_W         = 6;
   localparam int ST_IN_EMPTY  = 0;
   localparam int ST_IN_FULL   = 1;
   localparam int ST_OUT_EMPTY = 2;
   localparam int ST_OUT_FULL  = 3;
   localparam int ST_OVF       = 4;
   localparam int ST_UNF       = 5;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO used for both directions of every io_chan channel.
// Ports:
//   CLK    in   clock, rising edge
//   AR     in   asynchronous active-low reset (clears pointers/count, not storage)
//   push   in   write request; honoured when not full, or when a pop happens too
//   wdata  in   W-bit write word
//   pop    in   read request; ignored when empty
//   rdata  out  head word, forced to 0 while empty
//   full   out  count == DEPTH
//   empty  out  count == 0
module io_fifo
   import scp_io_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         CLK,
   input  logic         AR,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot the push will land in.
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? '0 : mem_q[rptr_q];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge CLK or negedge AR) begin
      if (!AR) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/io_chan.sv
// Buffered multi-channel I/O unit between the shared DATA bus and NCH
// external valid/ready ports. Each channel has an input FIFO, an output
// FIFO and sticky UNF/OVF flags.
// Parameters: DW bus width, PW external port width (PW <= DW-3; not named
// IOW because that name is the write strobe), NCH channels, DEPTH entries.
// Ports:
//   CLK, AR                clock, asynchronous active-low reset
//   SEL                    channel addressed by bus operations
//   IOS / IOR / IOW        status read / input pop / output push (IOS > IOR > IOW)
//   DATA                   shared bus, driven only during IOR/IOS
//   IN_DATA/VALID/READY    external input ports, channel c at [c*PW +: PW]
//   OUT_DATA/VALID/READY   external output ports (FIFO heads)
module io_chan
   import scp_io_pkg::*;
#(
   parameter int  DW    = 16,
   parameter int  PW    = 8,
   parameter int  NCH   = 2,
   parameter int  DEPTH = 4,
   localparam int SW    = (NCH > 1) ? clog2(NCH) : 1
) (
   input  logic              CLK,
   input  logic              AR,
   input  logic [SW-1:0]     SEL,
   input  logic              IOR,
   input  logic              IOW,
   input  logic              IOS,
   inout  wire  [DW-1:0]     DATA,
   input  logic [NCH*PW-1:0] IN_DATA,
   input  logic [NCH-1:0]    IN_VALID,
   output logic [NCH-1:0]    IN_READY,
   output logic [NCH*PW-1:0] OUT_DATA,
   output logic [NCH-1:0]    OUT_VALID,
   input  logic [NCH-1:0]    OUT_READY
);

   logic              sel_ok, op_r, op_w;
   logic [NCH-1:0]    hit, clr;
   logic [NCH-1:0]    in_full, in_empty, in_push, in_pop;
   logic [NCH-1:0]    out_full, out_empty, out_push, out_pop;
   logic [NCH-1:0]    unf_q, unf_d, ovf_q, ovf_d, unf_set, ovf_set;
   logic [PW-1:0]     in_rdata [NCH];
   logic [ST_W-1:0]   status   [NCH];
   logic [DW-1:0]     rd_data;
   logic              unused_hi;

   assign sel_ok = (32'(SEL) < NCH);
   assign op_r   = IOR & ~IOS;
   assign op_w   = IOW & ~IOS & ~IOR;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign hit[c]       = sel_ok & (SEL == SW'(c));
      assign clr[c]       = IOS & hit[c];
      assign in_pop[c]    = op_r & hit[c];
      assign IN_READY[c]  = AR & ~in_full[c];
      assign in_push[c]   = IN_VALID[c] & IN_READY[c];
      assign OUT_VALID[c] = ~out_empty[c];
      assign out_pop[c]   = OUT_VALID[c] & OUT_READY[c];
      assign out_push[c]  = op_w & hit[c];
      assign unf_set[c]   = in_pop[c] & in_empty[c];
      assign ovf_set[c]   = out_push[c] & out_full[c] & ~out_pop[c];

      io_fifo #(.W(PW), .DEPTH(DEPTH)) u_in (
         .CLK   (CLK),
         .AR    (AR),
         .push  (in_push[c]),
         .wdata (IN_DATA[c*PW +: PW]),
         .pop   (in_pop[c]),
         .rdata (in_rdata[c]),
         .full  (in_full[c]),
         .empty (in_empty[c])
      );

      io_fifo #(.W(PW), .DEPTH(DEPTH)) u_out (
         .CLK   (CLK),
         .AR    (AR),
         .push  (out_push[c]),
         .wdata (DATA[PW-1:0]),
         .pop   (out_pop[c]),
         .rdata (OUT_DATA[c*PW +: PW]),
         .full  (out_full[c]),
         .empty (out_empty[c])
      );
   end

   // A set in the same cycle as a status-read clear leaves the flag at 1.
   assign unf_d = (unf_q & ~clr) | unf_set;
   assign ovf_d = (ovf_q & ~clr) | ovf_set;

   always_ff @(posedge CLK or negedge AR) begin
      if (!AR) begin
         unf_q <= '0;
         ovf_q <= '0;
      end else begin
         unf_q <= unf_d;
         ovf_q <= ovf_d;
      end
   end

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         status[c]               = '0;
         status[c][ST_IN_EMPTY]  = in_empty[c];
         status[c][ST_IN_FULL]   = in_full[c];
         status[c][ST_OUT_EMPTY] = out_empty[c];
         status[c][ST_OUT_FULL]  = out_full[c];
         status[c][ST_OVF]       = ovf_q[c];
         status[c][ST_UNF]       = unf_q[c];
      end
   end

   // Unselected or out-of-range reads return 0; an empty input FIFO reads 0.
   always_comb begin
      rd_data = '0;
      for (int c = 0; c < NCH; c++) begin
         if (hit[c]) rd_data = IOS ? DW'(status[c]) : DW'(in_rdata[c]);
      end
   end

   assign DATA      = (AR & (IOS | IOR)) ? rd_data : {DW{1'bz}};
   assign unused_hi = ^DATA[DW-1:PW];

endmodule
